urish_256_bits_dff_mem: RTL and testbench

// - 256-bit (32 x 8) flip-flop-based RAM wrapped in the standard TinyTapeout user-project pin interface.
// - Single port, synchronous write, registered read.
// - Sits directly behind the TT mux; address, write-enable and data come from the dedicated and bidir pads.
//

---
 rtl/urish_256_bits_dff_mem.sv | 93 +++++++++
 tb/tb_urish_256_bits_dff_mem.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/urish_256_bits_dff_mem.sv
// ---------------------------------------------------------------------------
// urish_256_bits_dff_mem
// 32 x 8 flip-flop RAM behind the TinyTapeout user-project pin interface.
// Single port, synchronous write, registered read (1-cycle latency).
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - synchronous active-low reset (clears memory and read register)
//   ena      - design selected; writes are blocked while low
//   ui_in    - [4:0] address, [6:5] ignored, [7] write enable
//   uio_in   - write data
//   uo_out   - registered read data
//   uio_out  - tied 8'h00
//   uio_oe   - tied 8'h00 (all bidir pins are inputs)
//   VPWR/VGND- power pins, present only when USE_POWER_PINS is defined
//
// Build option:
//   WRITE_THROUGH_EN - when defined, a write cycle forwards uio_in to uo_out;
//                      otherwise uo_out returns the old byte (read-before-write).
// ---------------------------------------------------------------------------
module urish_256_bits_dff_mem (
`ifdef USE_POWER_PINS
  inout  wire        VPWR,
  inout  wire        VGND,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  // Field view of the dedicated input pads
  typedef struct packed {
    logic              we;
    logic [1:0]        rsvd;
    logic [ADDR_W-1:0] addr;
  } ui_ctrl_t;

  ui_ctrl_t          ctrl_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_next_c;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Address bits [6:5] are deliberately ignored; consume them here
  logic unused_rsvd;
  assign unused_rsvd = ^ctrl_c.rsvd;

  // Decode pads and qualify the write with ena
  always_comb begin
    ctrl_c  = ui_ctrl_t'(ui_in);
    wr_en_c = ena & ctrl_c.we;
  end

  // Next read value: old contents, or forwarded write data when enabled
  always_comb begin
    rd_next_c = mem[ctrl_c.addr];
`ifdef WRITE_THROUGH_EN
    if (wr_en_c) begin
      rd_next_c = uio_in;
    end
`endif
  end

  // Storage and read register; reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en_c) begin
        mem[ctrl_c.addr] <= uio_in;
      end
      rd_q <= rd_next_c;
    end
  end

  assign uo_out  = rd_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_urish_256_bits_dff_mem.sv
module tb_urish_256_bits_dff_mem;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  urish_256_bits_dff_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [7:0] data);
    ena    = 1'b1;
    ui_in  = {1'b1, 2'b00, addr};
    uio_in = data;
    tick();
    ui_in  = {1'b0, 2'b00, addr};
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick();
    tick();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uo_out: got %h expected 00", uo_out);
    end
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ui_in = {1'b0, 2'b00, 5'(a)};
      tick();
      checks++;
      if (uo_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_read addr %0d: got %h expected 00", a, uo_out);
      end
    end
  endtask

  task automatic test_write_readback();
    do_write(5'd3, 8'hA5);
    do_write(5'd31, 8'h5A);
    ui_in = {1'b0, 2'b00, 5'd3};
    tick();
    checks++;
    if (uo_out !== 8'hA5) begin
      errors++;
      $display("FAIL readback addr 3: got %h expected a5", uo_out);
    end
    ui_in = {1'b0, 2'b00, 5'd31};
    tick();
    checks++;
    if (uo_out !== 8'h5A) begin
      errors++;
      $display("FAIL readback addr 31: got %h expected 5a", uo_out);
    end
    ui_in = {1'b0, 2'b00, 5'd4};
    tick();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL readback addr 4: got %h expected 00", uo_out);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_v;
    for (int a = 0; a < 32; a++) begin
      do_write(5'(a), 8'(a) ^ 8'hC3);
    end
    for (int hi = 0; hi < 2; hi++) begin
      for (int a = 0; a < 32; a++) begin
        exp_v = 8'(a) ^ 8'hC3;
        ui_in = {1'b0, (hi == 1) ? 2'b11 : 2'b00, 5'(a)};
        tick();
        checks++;
        if (uo_out !== exp_v) begin
          errors++;
          $display("FAIL sweep hi=%0d addr %0d: got %h expected %h", hi, a, uo_out, exp_v);
        end
      end
    end
  endtask

  task automatic test_write_gating();
    ena    = 1'b0;
    ui_in  = {1'b1, 2'b00, 5'd7};
    uio_in = 8'hFF;
    tick();
    checks++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL gating_bidir: got oe %h out %h expected 00 00", uio_oe, uio_out);
    end
    tick();
    ena   = 1'b1;
    ui_in = {1'b0, 2'b00, 5'd7};
    tick();
    checks++;
    if (uo_out !== 8'hC4) begin
      errors++;
      $display("FAIL gating addr 7: got %h expected c4", uo_out);
    end
    checks++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL gating_bidir_end: got oe %h out %h expected 00 00", uio_oe, uio_out);
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] exp_first;
`ifdef WRITE_THROUGH_EN
    exp_first = 8'h22;
`else
    exp_first = 8'h11;
`endif
    do_write(5'd9, 8'h11);
    do_write(5'd9, 8'h22);
    checks++;
    if (uo_out !== exp_first) begin
      errors++;
      $display("FAIL same_cycle_first: got %h expected %h", uo_out, exp_first);
    end
    tick();
    checks++;
    if (uo_out !== 8'h22) begin
      errors++;
      $display("FAIL same_cycle_second: got %h expected 22", uo_out);
    end
  endtask

  task automatic test_reset_vs_write();
    do_write(5'd2, 8'h44);
    tick();
    checks++;
    if (uo_out !== 8'h44) begin
      errors++;
      $display("FAIL rvw_pre addr 2: got %h expected 44", uo_out);
    end
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = {1'b1, 2'b00, 5'd2};
    uio_in = 8'h77;
    tick();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL rvw_in_reset: got %h expected 00", uo_out);
    end
    rst_n = 1'b1;
    ui_in = {1'b0, 2'b00, 5'd2};
    tick();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL rvw addr 2: got %h expected 00", uo_out);
    end
    ui_in = {1'b0, 2'b00, 5'd31};
    tick();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL rvw addr 31: got %h expected 00", uo_out);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_write_readback();
    test_sweep();
    test_write_gating();
    test_same_cycle();
    test_reset_vs_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
